// File: rtl/spi_pkg.sv
// Shared SPI constants and helpers, common to the control unit and the shift datapath
// so that frame lengths and counter widths stay consistent.
package spi_pkg;

  localparam int SPI_WIDTH = 8;

  // Counter width able to hold 0..w inclusive.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  typedef struct packed {
    logic load_tx;
    logic shift_tx;
    logic shift_rx;
    logic end_tx;
  } strobe_t;

endpackage

// File: rtl/spi_shift_dp_if.sv
// Bus between the SPI control unit / host and the shift datapath.
interface spi_shift_dp_if
  import spi_pkg::*;
#(
  parameter int WIDTH = SPI_WIDTH
);
  logic [WIDTH-1:0] TxData;
  logic             LoadTx;
  logic             ShiftTx;
  logic             ShiftRx;
  logic             EndTx;
  logic             MISO;
  logic             MOSI;
  logic [WIDTH-1:0] RxData;
  logic             RxValid;
  logic             Busy;
  logic             Err;

  modport master (
    output TxData, LoadTx, ShiftTx, ShiftRx, EndTx, MISO,
    input  MOSI, RxData, RxValid, Busy, Err
  );

  modport slave (
    input  TxData, LoadTx, ShiftTx, ShiftRx, EndTx, MISO,
    output MOSI, RxData, RxValid, Busy, Err
  );
endinterface

// File: rtl/spi_edge_det.sv
// One-flop rising-edge detector for a level strobe.
module spi_edge_det (
  input  logic Clk,
  input  logic Rst,
  input  logic level_i,
  output logic rise_o
);
  logic prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Rst) prev_q <= 1'b0;
    else     prev_q <= level_i;
  end

  assign rise_o = level_i & ~prev_q;
endmodule

// File: rtl/spi_shift_dp.sv
// SPI shift datapath: MSB-first transmit serialiser, receive deserialiser and frame checks,
// driven by the rising edges of the control unit's level strobes.
module spi_shift_dp
  import spi_pkg::*;
#(
  parameter int WIDTH = SPI_WIDTH
) (
  input logic          Clk,
  input logic          Rst,
  spi_shift_dp_if.slave bus
);
  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  strobe_t rise;

  spi_edge_det u_load_det  (.Clk(Clk), .Rst(Rst), .level_i(bus.LoadTx),  .rise_o(rise.load_tx));
  spi_edge_det u_stx_det   (.Clk(Clk), .Rst(Rst), .level_i(bus.ShiftTx), .rise_o(rise.shift_tx));
  spi_edge_det u_srx_det   (.Clk(Clk), .Rst(Rst), .level_i(bus.ShiftRx), .rise_o(rise.shift_rx));
  spi_edge_det u_end_det   (.Clk(Clk), .Rst(Rst), .level_i(bus.EndTx),   .rise_o(rise.end_tx));

  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [CW-1:0]    tx_cnt_q,   tx_cnt_d;
  logic [CW-1:0]    rx_cnt_q,   rx_cnt_d;
  logic [WIDTH-1:0] rx_data_q,  rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             busy_q,     busy_d;
  logic             err_q,      err_d;

  // NOTE: every always_comb output is defaulted first so no path can infer a latch.
  always_comb begin
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    tx_cnt_d   = tx_cnt_q;
    rx_cnt_d   = rx_cnt_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    busy_d     = busy_q;
    err_d      = err_q;

    if (rise.load_tx) begin
      // A load discards any other edge arriving in the same cycle.
      tx_shift_d = bus.TxData;
      tx_cnt_d   = '0;
      rx_cnt_d   = '0;
      busy_d     = 1'b1;
      err_d      = 1'b0;
    end else begin
      if (rise.shift_tx) begin
        if (!busy_q || tx_cnt_q == CNT_FULL) begin
          err_d = 1'b1;
        end else begin
          tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
          tx_cnt_d   = tx_cnt_q + CNT_ONE;
        end
      end

      if (rise.shift_rx) begin
        if (!busy_q || rx_cnt_q == CNT_FULL) begin
          err_d = 1'b1;
        end else begin
          rx_shift_d = {rx_shift_q[WIDTH-2:0], bus.MISO};
          rx_cnt_d   = rx_cnt_q + CNT_ONE;
        end
      end

      // Completion uses the post-shift count so a coincident final ShiftRx is captured.
      if (rise.end_tx) begin
        busy_d = 1'b0;
        if (rx_cnt_d == CNT_FULL) begin
          rx_data_d  = rx_shift_d;
          rx_valid_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign bus.MOSI    = tx_shift_q[WIDTH-1];
  assign bus.RxData  = rx_data_q;
  assign bus.RxValid = rx_valid_q;
  assign bus.Busy    = busy_q;
  assign bus.Err     = err_q;
endmodule

// File: doc/spi_shift_dp.md
# spi_shift_dp

SPI shift-register datapath sitting directly downstream of the SPI control unit. It consumes the control unit's LoadTx, ShiftTx, ShiftRx and EndTx strobes, serialises a parallel transmit word onto MOSI MSB-first, and deserialises MISO into a parallel receive word. Each frame is a write phase of WIDTH bits followed by a read phase of WIDTH bits. At frame end it presents the received word to the host with a one-cycle valid pulse.

## Interface
- WIDTH, 8, frame length in bits per phase; must be at least 2.
- Clk  in  1  system clock; all logic on its rising edge.
- Rst  in  1  synchronous, active-high reset.
- TxData  in  WIDTH  parallel word to transmit; sampled on the LoadTx rising edge.
- LoadTx  in  1  level strobe from the control unit; a rising edge loads TxData.
- ShiftTx  in  1  level strobe; a rising edge advances MOSI by one bit.
- ShiftRx  in  1  level strobe; a rising edge samples MISO.
- EndTx  in  1  level strobe; a rising edge closes the frame.
- MISO  in  1  serial input; already synchronised upstream in the pad ring.
- MOSI  out  1  serial output; registered; equal to the shift-register MSB.
- RxData  out  WIDTH  last completed receive word; holds its value until the next valid frame.
- RxValid  out  1  one-cycle pulse when RxData updates.
- Busy  out  1  high from a load until frame end.
- Err  out  1  sticky protocol-error flag; cleared by Rst or by the next LoadTx edge.

## Operation
- Strobe handling:
  - All four strobes are levels, each held for several cycles. Only the 0→1 transition acts.
  - Rising edge = input high now AND registered previous level low.
  - Holding a strobe high for N cycles produces exactly one action.
- LoadTx edge:
  - TxShift←TxData, TxCnt←0, RxCnt←0, Busy←1, Err←0.
  - MOSI shows TxData[WIDTH-1].
- ShiftTx edge, TxCnt<WIDTH:
  - TxShift←{TxShift[WIDTH-2:0],0}, TxCnt++.
  - After WIDTH shifts MOSI idles at 0.
- ShiftTx edge, TxCnt==WIDTH: no shift, Err←1.
- ShiftRx edge, RxCnt<WIDTH: RxShift←{RxShift[WIDTH-2:0],MISO}, RxCnt++.
- ShiftRx edge, RxCnt==WIDTH: no shift, Err←1.
- EndTx edge, RxCnt==WIDTH: RxData←RxShift, RxValid←1 for one cycle, Busy←0.
- EndTx edge, RxCnt!=WIDTH: RxData unchanged, no RxValid, Err←1, Busy←0.
- Counters TxCnt/RxCnt: $clog2(WIDTH+1) bits each, saturating at WIDTH; they never wrap.
- Shift edge while Busy==0: ignored, Err←1.
- Priority for simultaneous edges:
  - LoadTx beats ShiftTx/ShiftRx/EndTx in the same cycle; the others are discarded.
  - ShiftRx together with EndTx: the shift is applied first, and the completion check and RxData capture use the updated RxCnt/RxShift.
  - ShiftTx and ShiftRx together: both apply independently.

## Timing
- Latency: every action is visible on outputs one Clk after the edge where the strobe is first sampled high.
- MOSI is stable from that point until the next ShiftTx/LoadTx action. The control unit guarantees at least one Pulse period between a shift and the opposing SCK edge.
- MISO is sampled on the same Clk edge that detects ShiftRx high.
- RxValid: high for exactly one cycle; RxData is valid in that cycle and afterwards.
- Reset values, all outputs: MOSI=0, RxData=0, RxValid=0, Busy=0, Err=0.
- Reset values, internal state: TxShift, RxShift, counters and edge-detector history all 0.
- Reset mid-frame: state is fully cleared with no RxValid. A strobe held high through reset is seen as an edge when sampled high in the first cycle after Rst deasserts, because the history register is 0.

## Structure
- Shared package spi_pkg:
  - SPI_WIDTH default (8).
  - Count-width function.
  - Shared with the control unit so its 16-count frame and this block's 2×WIDTH shifts stay consistent.
- Sub-module spi_edge_det: one-flop rising-edge detector with synchronous active-high reset; instantiated four times, once per strobe.
- Remainder is flat: two shift registers, two counters, output registers.

## Test plan
- Nominal frame:
  - Stimulus: LoadTx with TxData=8'hA5; 8 ShiftTx edges; 8 ShiftRx edges with MISO=0,0,1,1,1,1,0,0; then EndTx.
  - Response: MOSI sequence 1,0,1,0,0,1,0,1 then 0; RxData=8'h3C; RxValid high one cycle; Busy falls; Err=0.
- Held strobe: ShiftTx held high 5 cycles → exactly one shift, TxCnt=1.
- Overrun: 9th ShiftTx edge → Err=1, MOSI stays 0, TxCnt stays 8. The next LoadTx clears Err.
- Short frame:
  - Stimulus: EndTx after only 5 ShiftRx edges, with previous RxData=8'h3C.
  - Response: no RxValid, RxData stays 8'h3C, Err=1.
- Simultaneous edges:
  - LoadTx and ShiftTx rise in the same cycle with TxData=8'h80 → MOSI=1 and TxCnt=0.
  - 8th ShiftRx and EndTx rise in the same cycle → RxValid with all 8 bits captured.
- Reset mid-frame: Rst after 3 shifts → all outputs 0 next cycle. A fresh 8'hFF frame then completes correctly.
